// File: rtl/ppu_pixel_mixer.sv
// DMG pixel mixer: pops BG/OBJ FIFO heads, drops the SCX fine-scroll pixels at line start,
// resolves BG/OBJ priority and palettes, and emits one registered shade per screen column.
module ppu_pixel_mixer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [2:0]  scx_fine,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  bgp,
  input  logic [7:0]  obp0,
  input  logic [7:0]  obp1,
  input  logic [12:0] bg_px,
  input  logic        bg_empty,
  input  logic [12:0] obj_px,
  input  logic        stall,
  output logic        bg_pop,
  output logic        obj_pop,
  output logic        lcd_valid,
  output logic [7:0]  lcd_x,
  output logic [1:0]  lcd_shade,
  output logic        line_done
);

  localparam logic [7:0] LastX = 8'd159;

  typedef enum logic [1:0] {StIdle, StDiscard, StPush} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [2:0]  disc_q, disc_d;
  logic        pop_ok;
  logic        push_pop;

  logic [1:0]  bg_idx;
  logic [1:0]  obj_color;
  logic        obj_vis;
  logic [7:0]  pal;
  logic [1:0]  pal_sel;
  logic [1:0]  mix_shade;

  // BG palette/attribute fields and the upper LCDC bits play no part in DMG mixing.
  logic unused_bits;
  assign unused_bits = ^{lcdc[7:2], bg_px[10:0], obj_px[10:9], obj_px[7:2]};

  // Pop qualification shared by the FSM, the counters and the output register.
  always_comb begin
    pop_ok   = (state_q != StIdle) && !bg_empty && !stall;
    push_pop = pop_ok && (state_q == StPush);
  end

  // State and counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= 8'd0;
      disc_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      disc_q  <= disc_d;
    end
  end

  // Next-state and counter logic; line_start restarts the line from any state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    disc_d  = disc_q;
    if (line_start) begin
      state_d = (scx_fine == 3'd0) ? StPush : StDiscard;
      disc_d  = scx_fine;
      x_d     = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDiscard: begin
          if (pop_ok) begin
            disc_d = disc_q - 3'd1;
            if (disc_q == 3'd1) state_d = StPush;
          end
        end
        StPush: begin
          if (pop_ok) begin
            if (x_q == LastX) begin
              state_d = StIdle;
              x_d     = 8'd0;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO pop strobes; OBJ is only consumed once the scroll pixels are gone.
  always_comb begin
    bg_pop  = pop_ok;
    obj_pop = push_pop;
  end

  // BG/OBJ priority resolution and palette lookup for the current FIFO heads.
  always_comb begin
    bg_idx    = lcdc[0] ? bg_px[12:11] : 2'd0;
    obj_color = obj_px[12:11];
    obj_vis   = lcdc[1] && obj_px[0] && (obj_color != 2'd0) && !(obj_px[1] && (bg_idx != 2'd0));
    pal       = obj_vis ? (obj_px[8] ? obp1 : obp0) : bgp;
    pal_sel   = obj_vis ? obj_color : bg_idx;
    unique case (pal_sel)
      2'd0:    mix_shade = pal[1:0];
      2'd1:    mix_shade = pal[3:2];
      2'd2:    mix_shade = pal[5:4];
      default: mix_shade = pal[7:6];
    endcase
  end

  // Output register: one-cycle latency, column/shade hold between pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_valid <= 1'b0;
      lcd_x     <= 8'd0;
      lcd_shade <= 2'd0;
      line_done <= 1'b0;
    end else begin
      lcd_valid <= push_pop;
      line_done <= push_pop && (x_q == LastX) && !line_start;
      if (push_pop) begin
        lcd_x     <= x_q;
        lcd_shade <= mix_shade;
      end
    end
  end

endmodule
